// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-index widths plus the MEM-stage FSM states.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/mem_stage.sv
// Memory-access stage: data-cache request/dhit handshake, load buffering and
// the producer side of the MEM/WB latch.
module mem_stage
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        advance,
    input  logic        em_valid,
    input  word_t       em_ALUout,
    input  word_t       em_storedata,
    input  word_t       em_instr,
    input  word_t       em_npc,
    input  logic [15:0] em_imm,
    input  regbits_t    em_rd,
    input  regbits_t    em_rt,
    input  logic [1:0]  em_regDest,
    input  logic        em_dREN,
    input  logic        em_dWEN,
    input  logic        em_JAL,
    input  logic        em_LUI,
    input  logic        em_halt,
    input  logic        em_memToReg,
    input  logic        em_regWrite,
    input  logic        em_imemREN,
    output logic        dmemREN,
    output logic        dmemWEN,
    output word_t       dmemaddr,
    output word_t       dmemstore,
    input  logic        dhit,
    input  word_t       dmemload,
    output logic        mem_busy,
    output logic        halted,
    output word_t       ALUout_in,
    output word_t       instr_in,
    output word_t       npc_in,
    output word_t       dmemload_in,
    output logic [15:0] imm_in,
    output regbits_t    rd_in,
    output regbits_t    rt_in,
    output logic [1:0]  regDest_in,
    output logic        imemREN_in,
    output logic        JAL_in,
    output logic        LUI_in,
    output logic        halt_in,
    output logic        memToReg_in,
    output logic        regWrite_in,
    output logic        dhit_in
);

    state_t state, next_state;
    word_t  load_buf;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            load_buf <= '0;
            halted   <= 1'b0;
        end else begin
            state <= next_state;
            if (state == REQ && dhit)
                load_buf <= dmemload;
            if (advance && em_valid && em_halt)
                halted <= 1'b1;
        end
    end

    always_comb begin
        next_state  = state;
        dmemREN     = 1'b0;
        dmemWEN     = 1'b0;
        dmemaddr    = '0;
        dmemstore   = '0;
        mem_busy    = 1'b0;
        dhit_in     = 1'b0;
        dmemload_in = '0;
        case (state)
            IDLE: begin
                if (em_valid && (em_dREN || em_dWEN) && !halted)
                    next_state = REQ;
            end
            REQ: begin
                // A write-flagged op never also reads; the read strobe is dropped.
                dmemREN   = em_dREN & ~em_dWEN;
                dmemWEN   = em_dWEN;
                dmemaddr  = {em_ALUout[31:2], 2'b00};
                dmemstore = em_storedata;
                mem_busy  = 1'b1;
                if (dhit)
                    next_state = DONE;
            end
            DONE: begin
                dhit_in     = 1'b1;
                dmemload_in = load_buf;
                if (advance)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath fields always mirror EX/MEM; control flags are squashed for bubbles.
    assign ALUout_in   = em_ALUout;
    assign instr_in    = em_instr;
    assign npc_in      = em_npc;
    assign imm_in      = em_imm;
    assign rd_in       = em_rd;
    assign rt_in       = em_rt;
    assign regDest_in  = em_regDest;
    assign imemREN_in  = em_imemREN  & em_valid;
    assign JAL_in      = em_JAL      & em_valid;
    assign LUI_in      = em_LUI      & em_valid;
    assign halt_in     = em_halt     & em_valid;
    assign memToReg_in = em_memToReg & em_valid;
    assign regWrite_in = em_regWrite & em_valid;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: per-scenario tasks with a load-data scoreboard.
module tb_mem_stage;
    import cpu_types_pkg::*;

    logic CLK = 1'b0, RST = 1'b1, advance = 1'b0, em_valid = 1'b0;
    word_t em_ALUout = '0, em_storedata = '0, em_instr = '0, em_npc = '0;
    logic [15:0] em_imm = '0;
    regbits_t em_rd = '0, em_rt = '0;
    logic [1:0] em_regDest = '0;
    logic em_dREN = 0, em_dWEN = 0, em_JAL = 0, em_LUI = 0, em_halt = 0;
    logic em_memToReg = 0, em_regWrite = 0, em_imemREN = 0;
    logic dhit = 1'b0;
    word_t dmemload = '0;
    logic dmemREN, dmemWEN, mem_busy, halted;
    word_t dmemaddr, dmemstore, ALUout_in, instr_in, npc_in, dmemload_in;
    logic [15:0] imm_in;
    regbits_t rd_in, rt_in;
    logic [1:0] regDest_in;
    logic imemREN_in, JAL_in, LUI_in, halt_in, memToReg_in, regWrite_in, dhit_in;

    int checks = 0, errors = 0;
    word_t exp_q[$];

    mem_stage dut (
        .CLK(CLK), .RST(RST), .advance(advance), .em_valid(em_valid),
        .em_ALUout(em_ALUout), .em_storedata(em_storedata), .em_instr(em_instr),
        .em_npc(em_npc), .em_imm(em_imm), .em_rd(em_rd), .em_rt(em_rt),
        .em_regDest(em_regDest), .em_dREN(em_dREN), .em_dWEN(em_dWEN),
        .em_JAL(em_JAL), .em_LUI(em_LUI), .em_halt(em_halt),
        .em_memToReg(em_memToReg), .em_regWrite(em_regWrite), .em_imemREN(em_imemREN),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .mem_busy(mem_busy), .halted(halted),
        .ALUout_in(ALUout_in), .instr_in(instr_in), .npc_in(npc_in),
        .dmemload_in(dmemload_in), .imm_in(imm_in), .rd_in(rd_in), .rt_in(rt_in),
        .regDest_in(regDest_in), .imemREN_in(imemREN_in), .JAL_in(JAL_in),
        .LUI_in(LUI_in), .halt_in(halt_in), .memToReg_in(memToReg_in),
        .regWrite_in(regWrite_in), .dhit_in(dhit_in)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    task automatic clear_em();
        em_valid = 0; em_ALUout = '0; em_storedata = '0; em_instr = '0; em_npc = '0;
        em_imm = '0; em_rd = '0; em_rt = '0; em_regDest = '0;
        em_dREN = 0; em_dWEN = 0; em_JAL = 0; em_LUI = 0; em_halt = 0;
        em_memToReg = 0; em_regWrite = 0; em_imemREN = 0;
        dhit = 0; dmemload = '0; advance = 0;
    endtask

    // Bounded wait for DONE, then score the buffered load word.
    task automatic wait_done(input string name);
        word_t exp;
        bit seen = 0;
        for (int i = 0; i < 16; i++) begin
            smp();
            if (dhit_in === 1'b1) begin seen = 1; break; end
            step();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: dhit_in never 1 within 16 cycles", name);
        end else begin
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXXXXXX;
            checks++;
            if (dmemload_in !== exp) begin
                errors++;
                $display("FAIL %s dmemload_in got %h exp %h", name, dmemload_in, exp);
            end
            checks++;
            if (mem_busy !== 1'b0 || dmemREN !== 1'b0 || dmemWEN !== 1'b0) begin
                errors++;
                $display("FAIL %s done_strobes busy=%b ren=%b wen=%b exp 0 0 0", name, mem_busy, dmemREN, dmemWEN);
            end
        end
    endtask

    task automatic test_reset();
        RST = 1; step(); step(); smp();
        checks++;
        if (mem_busy !== 0 || dmemREN !== 0 || dmemWEN !== 0 || dhit_in !== 0 ||
            dmemload_in !== 0 || halted !== 0 || dmemaddr !== 0) begin
            errors++;
            $display("FAIL reset busy=%b ren=%b wen=%b dhit_in=%b load=%h halted=%b addr=%h exp all 0",
                     mem_busy, dmemREN, dmemWEN, dhit_in, dmemload_in, halted, dmemaddr);
        end
        RST = 0; step();
    endtask

    task automatic test_alu();
        clear_em();
        em_valid = 1; em_ALUout = 32'h1234; em_regWrite = 1; em_rd = 5'd7; advance = 1;
        dhit = 1; dmemload = 32'hFFFF0000;  // stray hit in IDLE must be ignored
        smp();
        checks++;
        if (mem_busy !== 0 || ALUout_in !== 32'h1234 || dhit_in !== 0 || dmemREN !== 0 ||
            dmemWEN !== 0 || regWrite_in !== 1 || rd_in !== 5'd7) begin
            errors++;
            $display("FAIL alu busy=%b alu=%h dhit_in=%b ren=%b wen=%b rw=%b rd=%0d exp 0 1234 0 0 0 1 7",
                     mem_busy, ALUout_in, dhit_in, dmemREN, dmemWEN, regWrite_in, rd_in);
        end
        step(); smp();
        checks++;
        if (dhit_in !== 0 || dmemREN !== 0 || mem_busy !== 0) begin
            errors++;
            $display("FAIL alu_next dhit_in=%b ren=%b busy=%b exp 0 0 0", dhit_in, dmemREN, mem_busy);
        end
        clear_em(); step();
    endtask

    task automatic test_load();
        clear_em();
        em_valid = 1; em_dREN = 1; em_ALUout = 32'h0000_0103; em_memToReg = 1; em_regWrite = 1;
        smp();
        checks++;
        if (mem_busy !== 0 || dmemREN !== 0) begin
            errors++;
            $display("FAIL load_idle busy=%b ren=%b exp 0 0", mem_busy, dmemREN);
        end
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                dhit = 1; dmemload = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
            end
            smp();
            checks++;
            if (dmemaddr !== 32'h100 || dmemREN !== 1 || dmemWEN !== 0 || mem_busy !== 1) begin
                errors++;
                $display("FAIL load_req%0d addr=%h ren=%b wen=%b busy=%b exp 100 1 0 1",
                         i, dmemaddr, dmemREN, dmemWEN, mem_busy);
            end
            step();
        end
        dhit = 0; dmemload = '0;
        wait_done("load");
        step();
        dhit = 1; dmemload = 32'h0BADBAD0;  // stray hit in DONE must not disturb load_buf
        smp();
        checks++;
        if (dhit_in !== 1 || dmemload_in !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_hold dhit_in=%b load=%h exp 1 deadbeef", dhit_in, dmemload_in);
        end
        advance = 1; step(); clear_em(); smp();
        checks++;
        if (dhit_in !== 0 || dmemload_in !== 0 || mem_busy !== 0) begin
            errors++;
            $display("FAIL load_adv dhit_in=%b load=%h busy=%b exp 0 0 0", dhit_in, dmemload_in, mem_busy);
        end
        step();
    endtask

    task automatic test_store();
        clear_em();
        em_valid = 1; em_dWEN = 1; em_ALUout = 32'h40; em_storedata = 32'hA5A5A5A5;
        step();
        dhit = 1; dmemload = 32'h0000_00C3; exp_q.push_back(32'h0000_00C3);
        smp();
        checks++;
        if (dmemWEN !== 1 || dmemREN !== 0 || dmemstore !== 32'hA5A5A5A5 || dmemaddr !== 32'h40) begin
            errors++;
            $display("FAIL store_req wen=%b ren=%b data=%h addr=%h exp 1 0 a5a5a5a5 40",
                     dmemWEN, dmemREN, dmemstore, dmemaddr);
        end
        step(); dhit = 0;
        wait_done("store");
        advance = 1; step(); advance = 0;
        // Both strobes flagged: write wins.
        em_dREN = 1; em_dWEN = 1; em_ALUout = 32'h88; em_storedata = 32'h12345678;
        smp(); step();
        smp();
        checks++;
        if (dmemWEN !== 1 || dmemREN !== 0 || dmemaddr !== 32'h88) begin
            errors++;
            $display("FAIL store_both wen=%b ren=%b addr=%h exp 1 0 88", dmemWEN, dmemREN, dmemaddr);
        end
        dhit = 1; dmemload = 32'h77; exp_q.push_back(32'h77);
        step(); dhit = 0;
        wait_done("store_both");
        advance = 1; step(); clear_em(); step();
    endtask

    task automatic test_back_to_back();
        clear_em();
        em_valid = 1; em_dREN = 1; em_ALUout = 32'h200;
        step();
        dhit = 1; dmemload = 32'h11111111; exp_q.push_back(32'h11111111);
        smp();
        checks++;
        if (dmemaddr !== 32'h200 || dmemREN !== 1) begin
            errors++;
            $display("FAIL b2b_req1 addr=%h ren=%b exp 200 1", dmemaddr, dmemREN);
        end
        step(); dhit = 0;
        wait_done("b2b_1");
        advance = 1; step(); advance = 0;
        em_ALUout = 32'h204;
        smp();
        checks++;
        if (mem_busy !== 0 || dmemREN !== 0 || dhit_in !== 0) begin
            errors++;
            $display("FAIL b2b_idle busy=%b ren=%b dhit_in=%b exp 0 0 0", mem_busy, dmemREN, dhit_in);
        end
        step(); smp();
        checks++;
        if (dmemaddr !== 32'h204 || dmemREN !== 1 || mem_busy !== 1) begin
            errors++;
            $display("FAIL b2b_req2 addr=%h ren=%b busy=%b exp 204 1 1", dmemaddr, dmemREN, mem_busy);
        end
        dhit = 1; dmemload = 32'h22222222; exp_q.push_back(32'h22222222);
        step(); dhit = 0;
        wait_done("b2b_2");
        advance = 1; step(); clear_em(); step();
    endtask

    task automatic test_invalid();
        clear_em();
        em_valid = 0; em_regWrite = 1; em_dREN = 1; em_halt = 1; em_JAL = 1; advance = 1;
        em_ALUout = 32'hCAFE0000;
        smp();
        checks++;
        if (regWrite_in !== 0 || halt_in !== 0 || JAL_in !== 0 || ALUout_in !== 32'hCAFE0000) begin
            errors++;
            $display("FAIL invalid rw=%b halt=%b jal=%b alu=%h exp 0 0 0 cafe0000",
                     regWrite_in, halt_in, JAL_in, ALUout_in);
        end
        step(); smp();
        checks++;
        if (dmemREN !== 0 || mem_busy !== 0 || halted !== 0) begin
            errors++;
            $display("FAIL invalid_next ren=%b busy=%b halted=%b exp 0 0 0", dmemREN, mem_busy, halted);
        end
        clear_em(); step();
    endtask

    task automatic test_reset_mid_req();
        clear_em();
        em_valid = 1; em_dREN = 1; em_ALUout = 32'h300;
        step(); smp();
        checks++;
        if (dmemREN !== 1 || mem_busy !== 1) begin
            errors++;
            $display("FAIL rstreq_pre ren=%b busy=%b exp 1 1", dmemREN, mem_busy);
        end
        RST = 1; step(); RST = 0; smp();
        checks++;
        if (dmemREN !== 0 || mem_busy !== 0 || dhit_in !== 0 || dmemload_in !== 0 || dmemaddr !== 0) begin
            errors++;
            $display("FAIL rstreq_post ren=%b busy=%b dhit_in=%b load=%h addr=%h exp 0 0 0 0 0",
                     dmemREN, mem_busy, dhit_in, dmemload_in, dmemaddr);
        end
        clear_em(); step();
    endtask

    task automatic test_halt();
        clear_em();
        em_valid = 1; em_halt = 1; advance = 1;
        smp();
        checks++;
        if (halt_in !== 1 || halted !== 0) begin
            errors++;
            $display("FAIL halt_pre halt_in=%b halted=%b exp 1 0", halt_in, halted);
        end
        step(); clear_em();
        em_valid = 1; em_dREN = 1; em_ALUout = 32'h500;
        smp();
        checks++;
        if (halted !== 1) begin
            errors++;
            $display("FAIL halt_sticky halted=%b exp 1", halted);
        end
        for (int i = 0; i < 5; i++) begin
            step(); smp();
            checks++;
            if (dmemREN !== 0 || mem_busy !== 0 || halted !== 1) begin
                errors++;
                $display("FAIL halt_noreq%0d ren=%b busy=%b halted=%b exp 0 0 1", i, dmemREN, mem_busy, halted);
            end
        end
        step(); clear_em();
        RST = 1; step(); RST = 0; smp();
        checks++;
        if (halted !== 0) begin
            errors++;
            $display("FAIL halt_clear halted=%b exp 0", halted);
        end
    endtask

    initial begin
        clear_em();
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_back_to_back();
        test_invalid();
        test_reset_mid_req();
        test_halt();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
